mem_array_ctrl: RTL
===================

Name: mem_array_ctrl

Overview:
Sequencing controller for the word-based memory array. Accepts single read/write requests over a valid/ready interface and generates the array-side strobes: one-cold active-low word selects, rw and write data, with programmable setup, access and hold phases. Returns read data, or a write acknowledge, over a valid/ready response channel. Sits between the bus/CPU-side requester and the array of 8-bit word cells.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 4, request address width
DEPTH, 16, number of words; legal range 1 .. 2**ADDR_W
SETUP_CYC, 1, cycles rw/din are stable before select; must be >= 1
ACCESS_CYC, 2, cycles the select stays asserted; must be >= 1

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready at clk edge
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&&ready at clk edge
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  address >= DEPTH; no array access made
arr_sel_n  out  DEPTH  per-word select, active-low (0 = selected)
arr_rw  out  1  1 = write, 0 = read (array convention)
arr_din  out  DATA_W  data to array
arr_dout  in  DATA_W  data from the selected word

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- All arr_* outputs, rsp_valid, rsp_rdata and rsp_err are registered. req_ready is decoded from state and is 1 only in IDLE.
- Reset values: state IDLE, arr_sel_n all ones, arr_rw 0, arr_din 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, phase counter 0.
- FSM states: IDLE, SETUP, ACCESS, HOLD, RESP.
- IDLE: on req_valid, latch write, addr and wdata; go to SETUP. Later changes on req_* are ignored.
- SETUP (SETUP_CYC cycles): arr_rw = latched op, arr_din = wdata on writes (0 on reads), all selects high.
- ACCESS (ACCESS_CYC cycles): arr_sel_n[addr] = 0 and all other selects = 1. rw and din are held.
  - On a read, arr_dout is sampled at the clock edge that ends the last ACCESS cycle.
  - For an illegal address (addr >= DEPTH): no select is asserted and rsp_err is set.
- HOLD (1 cycle): all selects high, rw and din held. Then go to RESP.
- RESP: rsp_valid = 1 with rdata and err stable. On rsp_ready, go to IDLE, clear rsp_valid, set arr_rw to 0 and arr_din to 0.
- Latency: with accept at edge E0, rsp_valid rises after edge E0 + SETUP_CYC + ACCESS_CYC + 1. Defaults give 4 cycles.
- Back-to-back requests: the next request can be accepted no earlier than the cycle after the response handshake. There is one transaction in flight at most.
- rsp_ready held high: the response lasts exactly one cycle.
- rsp_ready low: the response and all array outputs are held indefinitely.
- Phase counter: counts down from the phase length minus 1. It is sized to clog2 of max(SETUP_CYC, ACCESS_CYC) + 1.
- arr_sel_n is never low in SETUP, HOLD, RESP or IDLE. At most one bit is ever low.
- rw and din never change while any select is low.
- Reset mid-operation: selects are released immediately (asynchronously) and the transaction is abandoned with no response. After reset deasserts, the block is in IDLE.
- Elaboration checks: SETUP_CYC >= 1, ACCESS_CYC >= 1, DEPTH <= 2**ADDR_W.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum ctrl_state_t (IDLE, SETUP, ACCESS, HOLD, RESP)
  - constants RW_WRITE = 1, RW_READ = 0, SEL_ON = 0, SEL_OFF = 1
- Sub-module mem_sel_decoder: combinational one-cold decoder.
  - Inputs: addr and en.
  - Outputs: sel_n[DEPTH] and an out-of-range flag.
  - The FSM registers its output.

Test Plan:
- Write then read: write addr 3, data 0x55. Expect arr_sel_n = 16'hFFF7 for exactly 2 cycles with arr_rw = 1 and arr_din = 0x55, and rsp_valid 4 cycles after accept. Then read addr 3 -> rsp_rdata 0x55, rsp_err 0.
- Strobe ordering check (assertion across all tests): rw/din stable for SETUP_CYC cycles before and 1 cycle after the select window. Never more than one select bit low.
- Backpressure: read addr 0 (array returns 0xFF) with rsp_ready low for 5 cycles -> rsp_valid and rdata 0xFF held, req_ready 0 throughout. Release -> IDLE next cycle.
- Illegal address with DEPTH = 12: read addr 13 -> arr_sel_n stays all ones, rsp_err 1, rsp_rdata 0.
- Reset mid-ACCESS: assert rst during a write select -> arr_sel_n all ones in the same cycle, no rsp_valid. A following read of addr 0 completes normally.
- Request stream with parameters SETUP_CYC = 2, ACCESS_CYC = 3: req_valid held high for 4 requests -> each accepted only in IDLE, each latency 6 cycles, no request lost or duplicated.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory array controller.
// Contents: FSM state encoding and the array strobe polarities.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        RESP
    } ctrl_state_t;

    // Array rw convention
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Word select polarity (active-low)
    localparam logic SEL_ON  = 1'b0;
    localparam logic SEL_OFF = 1'b1;

endpackage

// File: rtl/mem_sel_decoder.sv
// Combinational one-cold word-select decoder.
// Ports:
//   addr_i    - word address
//   en_i      - decode enable; all selects stay off when low
//   sel_n_c_o - per-word select, active-low, at most one bit low
//   oor_c_o   - address is outside the populated word range
module mem_sel_decoder
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              en_i,
    output logic [DEPTH-1:0]  sel_n_c_o,
    output logic              oor_c_o
);

    // Out-of-range addresses never match a populated word, so no select fires.
    always_comb begin
        oor_c_o = (32'(addr_i) >= DEPTH);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_n_c_o[i] = (en_i && (addr_i == ADDR_W'(i))) ? SEL_ON : SEL_OFF;
        end
    end

endmodule

// File: rtl/mem_array_ctrl.sv
// Sequencing controller for the word-based memory array.
// Takes one read/write request at a time, drives the array strobes through
// SETUP -> ACCESS -> HOLD phases and returns the result on a response channel.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   req_valid/req_ready             - request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata  - request payload
//   rsp_valid/rsp_ready             - response handshake
//   rsp_rdata, rsp_err              - read data (0 on writes/errors), address error
//   arr_sel_n, arr_rw, arr_din      - array strobes and write data
//   arr_dout                        - data from the selected word
module mem_array_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned ACCESS_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DEPTH-1:0]  arr_sel_n,
    output logic              arr_rw,
    output logic [DATA_W-1:0] arr_din,
    input  logic [DATA_W-1:0] arr_dout
);

    localparam int unsigned MAX_CYC = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    // Parameter legality
    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("mem_array_ctrl: SETUP_CYC must be >= 1");
    end
    if (ACCESS_CYC < 1) begin : g_bad_access
        $error("mem_array_ctrl: ACCESS_CYC must be >= 1");
    end
    if ((DEPTH < 1) || (64'(DEPTH) > (64'd1 << ADDR_W))) begin : g_bad_depth
        $error("mem_array_ctrl: DEPTH must be in 1 .. 2**ADDR_W");
    end

    ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0]  sel_n_q, sel_n_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req_ready_q;

    logic              dec_en;
    logic [DEPTH-1:0]  dec_sel_n;
    logic              dec_oor;

    mem_sel_decoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dec (
        .addr_i    (addr_q),
        .en_i      (dec_en),
        .sel_n_c_o (dec_sel_n),
        .oor_c_o   (dec_oor)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        sel_n_d     = sel_n_q;
        rw_d        = rw_q;
        din_d       = din_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        dec_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    rw_d    = req_write ? RW_WRITE : RW_READ;
                    din_d   = req_write ? req_wdata : '0;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    // Select and error flag are decided together on ACCESS entry
                    dec_en  = 1'b1;
                    sel_n_d = dec_sel_n;
                    err_d   = dec_oor;
                    cnt_d   = CNT_W'(ACCESS_CYC - 1);
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    sel_n_d = {DEPTH{SEL_OFF}};
                    // Read data captured on the edge closing the select window
                    if ((rw_q == RW_READ) && !err_q) begin
                        rdata_d = arr_dout;
                    end
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    rw_d        = RW_READ;
                    din_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset releases selects asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            sel_n_q     <= {DEPTH{SEL_OFF}};
            rw_q        <= RW_READ;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sel_n_q     <= sel_n_d;
            rw_q        <= rw_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= (state_d == IDLE);
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign arr_sel_n = sel_n_q;
    assign arr_rw    = rw_q;
    assign arr_din   = din_q;

endmodule
